// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, 50 MHz timing defaults and command bytes
package ps2_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_INHIBIT = 3'd1;
  localparam state_t S_RELEASE = 3'd2;
  localparam state_t S_DATA    = 3'd3;
  localparam state_t S_PARITY  = 3'd4;
  localparam state_t S_ACK     = 3'd5;
  localparam state_t S_WAIT    = 3'd6;
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain PS/2 line bundle
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic done;
  logic error;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  modport master(output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
                 input tx_ready, done, error, ps2_clk_oe, ps2_data_oe);
  modport slave(input tx_data, tx_valid, ps2_clk_in, ps2_data_in,
                output tx_ready, done, error, ps2_clk_oe, ps2_data_oe);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for PS/2 clock and data, clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_i,
  input  logic data_i,
  output logic clk_o,
  output logic data_o,
  output logic fall_o
);
  logic [1:0] clk_q, data_q;
  logic prev_q;
  // idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_q  <= '1;
      data_q <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q  <= {clk_q[0], clk_i};
      data_q <= {data_q[0], data_i};
      prev_q <= clk_q[1];
    end
  assign clk_o  = clk_q[1];
  assign data_o = data_q[1];
  assign fall_o = prev_q & ~clk_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 20
) (
  input logic clk,
  input logic rst,
  ps2_host_tx_if.slave bus
);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_MAX    = '1;
  logic s_clk, s_data, fall;
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic par_q, par_d, ack_ok_q, ack_ok_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic done_q, done_d, error_q, error_d;
  logic timeout;
  ps2_line_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .clk_i (bus.ps2_clk_in),
    .data_i(bus.ps2_data_in),
    .clk_o (s_clk),
    .data_o(s_data),
    .fall_o(fall)
  );
  assign timeout = (state_q inside {S_RELEASE, S_DATA, S_PARITY, S_ACK, S_WAIT}) && timer_q == TO_LAST;
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    if (timeout) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (bus.tx_valid) begin
            shreg_d   = bus.tx_data;
            par_d     = odd_parity(bus.tx_data);
            clk_oe_d  = 1'b1;
            data_oe_d = 1'b0;
            state_d   = S_INHIBIT;
          end
        end
        S_INHIBIT:
          if (timer_q == INH_LAST) begin
            data_oe_d = 1'b1;
            timer_d   = '0;
            state_d   = S_RELEASE;
          end
        S_RELEASE: begin
          clk_oe_d = 1'b0;
          idx_d    = '0;
          state_d  = S_DATA;
        end
        S_DATA:
          if (fall) begin
            data_oe_d = (idx_q == 4'd8) ? ~par_q : ~shreg_q[idx_q[2:0]];
            idx_d     = idx_q + 4'd1;
            state_d   = (idx_q == 4'd8) ? S_PARITY : S_DATA;
          end
        S_PARITY:
          if (fall) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        S_ACK:
          if (fall) begin
            ack_ok_d = ~s_data;
            state_d  = S_WAIT;
          end
        S_WAIT:
          if (s_clk && s_data) begin
            done_d  = ack_ok_q;
            error_d = ~ack_ok_q;
            state_d = S_IDLE;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  assign bus.tx_ready    = state_q == S_IDLE;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device BFM plus frame scoreboard for the PS/2 host transmitter
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 50;
  localparam int TO  = 2000;
  localparam int HP  = 20;
  logic clk = 1'b0, rst = 1'b1;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int run = 0, last_run = 0, rel_cyc = 0, err_cyc = 0;
  logic [10:0] exp_q[$];
  always #5 clk = ~clk;
  ps2_host_tx_if bus();
  assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.done && bus.error) both_cnt++;
    if (bus.ps2_clk_oe) run++;
    else if (run != 0) begin
      last_run = run;
      rel_cyc  = cyc;
      run      = 0;
    end
  end
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    exp_q.push_back(frame_of(d));
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic dev_frame(input bit ack, output logic [10:0] got, output bit ok);
    got = '0;
    ok  = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.ps2_clk_oe;
    end
    if (ok) begin
      repeat (HP) @(negedge clk);
      got[0] = bus.ps2_data_in;
      for (int i = 1; i <= 11; i++) begin
        if (i == 11 && ack) dev_data_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) got[i] = bus.ps2_data_in;
      end
      repeat (HP) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask
  task automatic wait_pulse(input int d0, input int e0);
    for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask
  task automatic score(input string name, input logic [10:0] got, input bit ok);
    logic [10:0] exp;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: no clock release seen, required release within 2000 cycles", name);
    end else if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: frame %b observed, no frame expected", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: frame %b observed, required %b", name, got, exp);
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: %b required 1", bus.tx_ready); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: %b required 0", bus.done); end
    if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error: %b required 0", bus.error); end
    if (bus.ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe: %b required 0", bus.ps2_clk_oe); end
    if (bus.ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe: %b required 0", bus.ps2_data_oe); end
  endtask
  task automatic test_nominal();
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send(CMD_SET_LEDS);
    dev_frame(1'b1, got, ok);
    checks += 2;
    if (got !== 11'b11_11101101_0) begin failures++; $display("FAIL nominal_bits: %b required %b", got, 11'b11_11101101_0); end
    if (last_run < INH) begin failures++; $display("FAIL nominal_inhibit: %0d cycles low, required >= %0d", last_run, INH); end
    score("nominal_frame", got, ok);
    wait_pulse(d0, e0);
    checks += 3;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL nominal_done: %0d pulses, required 1", done_cnt - d0); end
    if (err_cnt != e0) begin failures++; $display("FAIL nominal_error: %0d pulses, required 0", err_cnt - e0); end
    if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL nominal_ready: %b required 1", bus.tx_ready); end
  endtask
  task automatic test_parity();
    logic [10:0] got;
    bit ok;
    logic [7:0] pats[2];
    pats[0] = 8'h00;
    pats[1] = CMD_RESET;
    foreach (pats[k]) begin
      int d0 = done_cnt, e0 = err_cnt;
      send(pats[k]);
      dev_frame(1'b1, got, ok);
      checks++;
      if (got[9] !== 1'b1) begin failures++; $display("FAIL parity_%02h: parity %b required 1", pats[k], got[9]); end
      score("parity_frame", got, ok);
      wait_pulse(d0, e0);
      checks++;
      if (done_cnt - d0 != 1) begin failures++; $display("FAIL parity_done: %0d pulses, required 1", done_cnt - d0); end
    end
  endtask
  task automatic test_no_ack();
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h55);
    dev_frame(1'b0, got, ok);
    score("noack_frame", got, ok);
    wait_pulse(d0, e0);
    checks += 3;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL noack_error: %0d pulses, required 1", err_cnt - e0); end
    if (done_cnt != d0) begin failures++; $display("FAIL noack_done: %0d pulses, required 0", done_cnt - d0); end
    if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL noack_ready: %b required 1", bus.tx_ready); end
  endtask
  task automatic test_timeout();
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'hF4);
    void'(exp_q.pop_back());
    for (int i = 0; i < TO + 300 && err_cnt == e0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks += 5;
    if (err_cnt - e0 != 1) begin failures++; $display("FAIL timeout_error: %0d pulses, required 1", err_cnt - e0); end
    if (err_cyc - rel_cyc < TO - 3 || err_cyc - rel_cyc > TO + 3)
      begin failures++; $display("FAIL timeout_time: %0d cycles after release, required %0d +/-3", err_cyc - rel_cyc, TO); end
    if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_data_oe !== 1'b0)
      begin failures++; $display("FAIL timeout_oe: clk_oe=%b data_oe=%b required 0 0", bus.ps2_clk_oe, bus.ps2_data_oe); end
    if (done_cnt != d0) begin failures++; $display("FAIL timeout_done: %0d pulses, required 0", done_cnt - d0); end
    if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready: %b required 1", bus.tx_ready); end
    d0 = done_cnt;
    send(8'h3C);
    checks++;
    if (bus.ps2_clk_oe !== 1'b1) begin failures++; $display("FAIL timeout_next_accept: clk_oe=%b required 1", bus.ps2_clk_oe); end
    dev_frame(1'b1, got, ok);
    score("timeout_next_frame", got, ok);
    wait_pulse(d0, err_cnt);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL timeout_next_done: %0d pulses, required 1", done_cnt - d0); end
  endtask
  task automatic test_reset_mid();
    bit ok = 1'b0;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'hA5);
    void'(exp_q.pop_back());
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.ps2_clk_oe;
    end
    for (int i = 1; i <= 4; i++) begin
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i < 4) begin
        repeat (HP) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.ps2_data_oe !== 1'b1) begin failures++; $display("FAIL rstmid_pre: data_oe=%b required 1 (bit3 of A5 is 0)", bus.ps2_data_oe); end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_data_oe !== 1'b0)
      begin failures++; $display("FAIL rstmid_oe: clk_oe=%b data_oe=%b required 0 0", bus.ps2_clk_oe, bus.ps2_data_oe); end
    if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: %b required 1", bus.tx_ready); end
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt != e0)
      begin failures++; $display("FAIL rstmid_pulse: done=%0d error=%0d pulses, required 0 0", done_cnt - d0, err_cnt - e0); end
  endtask
  task automatic test_busy();
    logic [10:0] got;
    bit ok;
    int d0 = done_cnt, e0 = err_cnt;
    send(CMD_RESET);
    fork
      dev_frame(1'b1, got, ok);
      begin
        repeat (200) @(negedge clk);
        bus.tx_data  = 8'h12;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    score("busy_frame", got, ok);
    wait_pulse(d0, e0);
    repeat (100) @(negedge clk);
    checks += 3;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_done: %0d pulses, required 1", done_cnt - d0); end
    if (err_cnt != e0) begin failures++; $display("FAIL busy_error: %0d pulses, required 0", err_cnt - e0); end
    if (bus.ps2_clk_oe !== 1'b0 || bus.tx_ready !== 1'b1)
      begin failures++; $display("FAIL busy_idle: clk_oe=%b tx_ready=%b required 0 1", bus.ps2_clk_oe, bus.tx_ready); end
  endtask
  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_nominal();
    test_parity();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_busy();
    checks += 2;
    if (both_cnt != 0) begin failures++; $display("FAIL pulse_exclusive: %0d overlaps, required 0", both_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty: %0d frames left, required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
